pc_fetch_unit: RTL and testbench
================================

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 The module SHALL have one clock; reset is asynchronous and active-low (ports named clock and reset).
REQ-002 clock  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  asynchronous, active-low clear of all state.
REQ-004 PCControl  in  2  command from Control: 0 Stall, 1 Inc, 2 CondLoad, 3 reserved (treated as Stall).
REQ-005 JumpTaken  in  1  from the MEM stage: jump is taken this cycle.
REQ-006 BranchTaken  in  1  from the MEM stage: branch is taken this cycle.
REQ-007 JumpAddr  in  16  jump target from the EX/MEM register.
REQ-008 BranchAddr  in  16  branch target from the EX/MEM register.
REQ-009 IMemReq  out  1  instruction-memory read request.
REQ-010 IMemAddr  out  16  instruction-memory address; equals PC.
REQ-011 IMemReady  in  1  memory data valid this cycle.
REQ-012 IMemData  in  16  instruction word from memory.
REQ-013 PC  out  16  current program counter.
REQ-014 Instr  out  16  IF/ID instruction register.
REQ-015 PCPlus2  out  16  IF/ID incremented-PC register.
REQ-016 FetchBusy  out  1  high while a fetch waits on memory.
REQ-017 FetchCount  out  16  completed, unsquashed fetches; saturates at 16'hFFFF.

Function
REQ-018 The FSM SHALL have exactly two states: IDLE and WAIT.
REQ-019 IMemReq SHALL be combinational: high in IDLE when PCControl==Inc, and high in every WAIT cycle.
REQ-020 IDLE, Inc, IMemReady=1: in the same edge, Instr<=IMemData, PCPlus2<=PC+2, PC<=PC+2, FetchCount increments. Zero-wait latency is 1 cycle.
REQ-021 IDLE, Inc, IMemReady=0: enter WAIT. PC, Instr and PCPlus2 hold. FetchBusy=1 from the next cycle.
REQ-022 WAIT, IMemReady=1: complete the fetch per REQ-020, then return to IDLE.
REQ-023 IDLE, CondLoad: if JumpTaken, PC<=JumpAddr. Else if BranchTaken, PC<=BranchAddr. Else PC holds. Jump has priority when both are set.
REQ-024 Loaded targets SHALL have bit 0 forced to 0.
REQ-025 IDLE, Stall or reserved: all registers hold.
REQ-026 WAIT, CondLoad with a taken jump or branch: latch the target into a pending-redirect register and set a pending flag.
REQ-027 Completing a fetch with the pending flag set: Instr<=NOP (16'h0000), PCPlus2<=0, PC<=pending target, clear the flag. FetchCount does not increment.
REQ-028 In WAIT, Inc and Stall SHALL be ignored.
REQ-029 A second taken CondLoad in WAIT SHALL overwrite the pending target (last wins).
REQ-030 PC+2 SHALL wrap modulo 2^16: 16'hFFFE -> 16'h0000.
REQ-031 FetchCount SHALL hold at 16'hFFFF once reached.

Reset
REQ-032 Asserting reset SHALL immediately set PC=0, Instr=0, PCPlus2=0, FetchCount=0, pending flag=0, pending target=0, state=IDLE. IMemReq and FetchBusy go low.
REQ-033 Reset asserted during WAIT SHALL abandon the fetch; a late IMemReady after reset release is ignored unless a new request is issued.
REQ-034 After reset deasserts, the first active edge SHALL act on PCControl normally.

Structure
REQ-035 Shared package pmips_pkg SHALL hold: the PCControl encodings (PC_STALL=0, PC_INC=1, PC_CONDLOAD=2), NOP_INSTR=16'h0000, ADDR_W=16, and the state encoding for this block.
REQ-036 One sub-module, pc_next_mux, SHALL compute the combinational next-PC. Inputs: PC, command, taken flags, targets, pending state. Outputs: next-PC and load-enable.

Verification
REQ-037 PC=0, Inc with IMemReady=1 and IMemData=16'h1234 -> after one edge: PC=2, Instr=16'h1234, PCPlus2=2, FetchCount=1.
REQ-038 Inc with IMemReady low for 3 cycles, then high with 16'hABCD -> FetchBusy high for 3 cycles; PC updates only on the ready edge; state returns to IDLE.
REQ-039 CondLoad with JumpTaken=1, BranchTaken=1, JumpAddr=16'h0041, BranchAddr=16'h0080 -> PC=16'h0040.
REQ-040 CondLoad during WAIT with BranchTaken=1 and BranchAddr=16'h0100, then ready -> Instr=16'h0000, PC=16'h0100, FetchCount unchanged.
REQ-041 PC=16'hFFFE, Inc with ready -> PC=16'h0000, PCPlus2=16'h0000.
REQ-042 Reset mid-WAIT -> all outputs zero asynchronously; a later IMemReady pulse with no request -> no change.

Source files
------------

// File: rtl/pmips_pkg.sv
// Shared encodings for the pipelined MIPS front end: PC commands, widths and
// the fetch FSM state type.
package pmips_pkg;
  localparam int ADDR_W = 16;

  localparam logic [1:0] PC_STALL    = 2'd0;
  localparam logic [1:0] PC_INC      = 2'd1;
  localparam logic [1:0] PC_CONDLOAD = 2'd2;

  localparam logic [ADDR_W-1:0] NOP_INSTR = 16'h0000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } fetch_state_e;
endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC selection: sequential increment, jump/branch redirect,
// or a redirect that was deferred while a fetch was outstanding.
import pmips_pkg::*;

module pc_next_mux (
  input  logic              in_wait,
  input  logic [ADDR_W-1:0] pc,
  input  logic [1:0]        pc_control,
  input  logic              mem_ready,
  input  logic              jump_taken,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic [ADDR_W-1:0] branch_addr,
  input  logic              pend_vld,
  input  logic [ADDR_W-1:0] pend_addr,
  output logic              redir,
  output logic [ADDR_W-1:0] redir_addr,
  output logic [ADDR_W-1:0] next_pc,
  output logic              pc_load
);
  logic [ADDR_W-1:0] pc_inc;

  assign pc_inc     = pc + 16'd2;
  assign redir      = (pc_control == PC_CONDLOAD) && (jump_taken || branch_taken);
  // Jump wins over branch; instruction addresses are always halfword aligned.
  assign redir_addr = (jump_taken ? jump_addr : branch_addr) & 16'hFFFE;

  always_comb begin
    next_pc = pc;
    pc_load = 1'b0;
    if (!in_wait) begin
      if (pc_control == PC_INC && mem_ready) begin
        next_pc = pc_inc;
        pc_load = 1'b1;
      end else if (redir) begin
        next_pc = redir_addr;
        pc_load = 1'b1;
      end
    end else if (mem_ready) begin
      // A redirect arriving on the completing edge is the newest, so it wins.
      pc_load = 1'b1;
      if (redir)         next_pc = redir_addr;
      else if (pend_vld) next_pc = pend_addr;
      else               next_pc = pc_inc;
    end
  end
endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues instruction-memory reads,
// waits on slow memory and fills the IF/ID register.
import pmips_pkg::*;

module pc_fetch_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  PCControl,
  input  logic        JumpTaken,
  input  logic        BranchTaken,
  input  logic [15:0] JumpAddr,
  input  logic [15:0] BranchAddr,
  output logic        IMemReq,
  output logic [15:0] IMemAddr,
  input  logic        IMemReady,
  input  logic [15:0] IMemData,
  output logic [15:0] PC,
  output logic [15:0] Instr,
  output logic [15:0] PCPlus2,
  output logic        FetchBusy,
  output logic [15:0] FetchCount
);
  fetch_state_e state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, instr_q, instr_d, pcp2_q, pcp2_d, cnt_q, cnt_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic              pend_q, pend_d;

  logic              in_wait, done, squash, redir, pc_load;
  logic [ADDR_W-1:0] redir_addr, next_pc;

  assign in_wait = (state_q == ST_WAIT);
  assign done    = in_wait ? IMemReady : (PCControl == PC_INC && IMemReady);
  assign squash  = in_wait && (pend_q || redir);

  pc_next_mux u_next (
    .in_wait      (in_wait),
    .pc           (pc_q),
    .pc_control   (PCControl),
    .mem_ready    (IMemReady),
    .jump_taken   (JumpTaken),
    .branch_taken (BranchTaken),
    .jump_addr    (JumpAddr),
    .branch_addr  (BranchAddr),
    .pend_vld     (pend_q),
    .pend_addr    (pend_addr_q),
    .redir        (redir),
    .redir_addr   (redir_addr),
    .next_pc      (next_pc),
    .pc_load      (pc_load)
  );

  // FSM: state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (PCControl == PC_INC && !IMemReady) state_d = ST_WAIT;
      ST_WAIT: if (IMemReady)                         state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    IMemReq   = 1'b0;
    FetchBusy = 1'b0;
    case (state_q)
      ST_IDLE: IMemReq = (PCControl == PC_INC);
      ST_WAIT: begin
        IMemReq   = 1'b1;
        FetchBusy = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    pc_d        = pc_load ? next_pc : pc_q;
    instr_d     = instr_q;
    pcp2_d      = pcp2_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    if (done) begin
      pend_d = 1'b0;
      if (squash) begin
        instr_d = NOP_INSTR;
        pcp2_d  = '0;
      end else begin
        instr_d = IMemData;
        pcp2_d  = pc_q + 16'd2;
        if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
      end
    end else if (in_wait && redir) begin
      pend_d      = 1'b1;
      pend_addr_d = redir_addr;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q        <= '0;
      instr_q     <= '0;
      pcp2_q      <= '0;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
    end else begin
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      pcp2_q      <= pcp2_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
    end
  end

  assign PC         = pc_q;
  assign IMemAddr   = pc_q;
  assign Instr      = instr_q;
  assign PCPlus2    = pcp2_q;
  assign FetchCount = cnt_q;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: a behavioural model predicts each edge,
// expectations are queued on drive and compared after the edge.
module tb_pc_fetch_unit;
  logic        clock, reset;
  logic [1:0]  PCControl;
  logic        JumpTaken, BranchTaken, IMemReady;
  logic [15:0] JumpAddr, BranchAddr, IMemData;
  logic        IMemReq, FetchBusy;
  logic [15:0] IMemAddr, PC, Instr, PCPlus2, FetchCount;

  pc_fetch_unit dut (
    .clock(clock), .reset(reset), .PCControl(PCControl),
    .JumpTaken(JumpTaken), .BranchTaken(BranchTaken),
    .JumpAddr(JumpAddr), .BranchAddr(BranchAddr),
    .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemReady(IMemReady),
    .IMemData(IMemData), .PC(PC), .Instr(Instr), .PCPlus2(PCPlus2),
    .FetchBusy(FetchBusy), .FetchCount(FetchCount)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] pc, instr, pcp2, cnt;
    logic        busy;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, expv);
    end
  endtask

  // reference model state
  logic        m_wait, m_pend;
  logic [15:0] m_pc, m_instr, m_pcp2, m_cnt, m_paddr;

  task automatic model_reset();
    m_wait = 0; m_pend = 0; m_pc = 0; m_instr = 0; m_pcp2 = 0; m_cnt = 0; m_paddr = 0;
  endtask

  task automatic cyc(input logic [1:0] cmd, input logic jt, input logic bt,
                     input logic [15:0] ja, input logic [15:0] ba,
                     input logic rdy, input logic [15:0] data);
    logic redir, done;
    logic [15:0] tgt;
    exp_t e;
    PCControl = cmd; JumpTaken = jt; BranchTaken = bt;
    JumpAddr = ja; BranchAddr = ba; IMemReady = rdy; IMemData = data;
    #1;
    chk("imemreq", {15'd0, IMemReq}, {15'd0, m_wait || cmd == 2'd1});
    chk("imemaddr", IMemAddr, m_pc);
    redir = (cmd == 2'd2) && (jt || bt);
    tgt   = jt ? ja : ba;
    tgt[0] = 1'b0;
    done  = m_wait ? rdy : (cmd == 2'd1 && rdy);
    if (done) begin
      if (m_wait && (m_pend || redir)) begin
        m_instr = 16'h0000; m_pcp2 = 16'h0000;
        m_pc = redir ? tgt : m_paddr;
      end else begin
        m_instr = data; m_pcp2 = m_pc + 16'd2; m_pc = m_pc + 16'd2;
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end
      m_pend = 0; m_wait = 0;
    end else if (m_wait) begin
      if (redir) begin m_pend = 1; m_paddr = tgt; end
    end else if (cmd == 2'd1) begin
      m_wait = 1;
    end else if (redir) begin
      m_pc = tgt;
    end
    e.pc = m_pc; e.instr = m_instr; e.pcp2 = m_pcp2; e.cnt = m_cnt; e.busy = m_wait;
    exp_q.push_back(e);
    @(posedge clock); #1;
    e = exp_q.pop_front();
    chk("pc", PC, e.pc);
    chk("instr", Instr, e.instr);
    chk("pcplus2", PCPlus2, e.pcp2);
    chk("fetchcount", FetchCount, e.cnt);
    chk("fetchbusy", {15'd0, FetchBusy}, {15'd0, e.busy});
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pc"}, PC, 16'h0);
    chk({tag, "_instr"}, Instr, 16'h0);
    chk({tag, "_pcp2"}, PCPlus2, 16'h0);
    chk({tag, "_cnt"}, FetchCount, 16'h0);
    chk({tag, "_req_busy"}, {14'd0, IMemReq, FetchBusy}, 16'h0);
  endtask

  initial begin
    reset = 1'b0; PCControl = 0; JumpTaken = 0; BranchTaken = 0;
    JumpAddr = 0; BranchAddr = 0; IMemReady = 0; IMemData = 0;
    model_reset();
    #12;
    chk_zero("reset");
    @(posedge clock); #1 reset = 1'b1;

    // zero-wait fetch
    cyc(2'd1, 0, 0, 0, 0, 1, 16'h1234);
    chk("zw_pc", PC, 16'h0002); chk("zw_instr", Instr, 16'h1234);
    chk("zw_pcp2", PCPlus2, 16'h0002); chk("zw_cnt", FetchCount, 16'h0001);

    // three not-ready cycles, then ready
    cyc(2'd1, 0, 0, 0, 0, 0, 16'hDEAD);
    cyc(2'd0, 0, 0, 0, 0, 0, 16'hDEAD);
    cyc(2'd1, 0, 0, 0, 0, 0, 16'hDEAD);
    chk("slow_pc_hold", PC, 16'h0002);
    cyc(2'd0, 0, 0, 0, 0, 1, 16'hABCD);
    chk("slow_pc", PC, 16'h0004); chk("slow_instr", Instr, 16'hABCD);
    chk("slow_idle", {15'd0, FetchBusy}, 16'h0);

    // stall, reserved and untaken condload hold everything
    cyc(2'd0, 1, 1, 16'h0F00, 16'h0E00, 1, 16'h1111);
    cyc(2'd3, 1, 0, 16'h0F00, 16'h0E00, 1, 16'h2222);
    cyc(2'd2, 0, 0, 16'h0F00, 16'h0E00, 1, 16'h3333);
    chk("hold_pc", PC, 16'h0004);

    // jump beats branch, bit 0 cleared
    cyc(2'd2, 1, 1, 16'h0041, 16'h0080, 0, 0);
    chk("jmp_prio", PC, 16'h0040);
    cyc(2'd2, 0, 1, 16'h0041, 16'h0081, 0, 0);
    chk("branch", PC, 16'h0080);

    // redirect during wait squashes the fetch
    cyc(2'd1, 0, 0, 0, 0, 0, 0);
    cyc(2'd2, 0, 1, 0, 16'h0100, 0, 0);
    cyc(2'd1, 0, 0, 0, 0, 0, 0);
    cyc(2'd0, 0, 0, 0, 0, 1, 16'h5555);
    chk("sq_instr", Instr, 16'h0000); chk("sq_pc", PC, 16'h0100);
    chk("sq_cnt", FetchCount, 16'h0002);

    // last redirect wins
    cyc(2'd1, 0, 0, 0, 0, 0, 0);
    cyc(2'd2, 1, 0, 16'h0201, 0, 0, 0);
    cyc(2'd2, 0, 1, 0, 16'h0301, 0, 0);
    cyc(2'd0, 0, 0, 0, 0, 1, 16'h6666);
    chk("lastwin_pc", PC, 16'h0300);

    // redirect arriving on the completing edge
    cyc(2'd1, 0, 0, 0, 0, 0, 0);
    cyc(2'd2, 1, 0, 16'h0500, 0, 1, 16'h7777);
    chk("late_redir_pc", PC, 16'h0500);

    // wrap at top of address space
    cyc(2'd2, 1, 0, 16'hFFFF, 0, 0, 0);
    chk("wrap_pre", PC, 16'hFFFE);
    cyc(2'd1, 0, 0, 0, 0, 1, 16'h8888);
    chk("wrap_pc", PC, 16'h0000); chk("wrap_pcp2", PCPlus2, 16'h0000);

    // a few random cycles against the model
    for (int i = 0; i < 40; i++)
      cyc(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 16'($urandom));

    // asynchronous reset in the middle of a wait
    cyc(2'd1, 0, 0, 0, 0, 1, 16'h9999);
    cyc(2'd1, 0, 0, 0, 0, 0, 0);
    chk("pre_rst_busy", {15'd0, FetchBusy}, 16'h0001);
    #2 reset = 1'b0;
    PCControl = 2'd0;
    #1 chk_zero("async_rst");
    model_reset();
    @(posedge clock); #1 reset = 1'b1;
    cyc(2'd0, 0, 0, 0, 0, 1, 16'hAAAA);
    chk_zero("late_ready");
    cyc(2'd1, 0, 0, 0, 0, 1, 16'hBEEF);
    chk("post_rst_pc", PC, 16'h0002);

    if (exp_q.size() != 0) chk("queue_drained", 16'(exp_q.size()), 16'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
